rmt_tcam_stage: RTL and testbench
=================================

Name: rmt_tcam_stage

Overview:
Parametrised single match-action stage, successor to the fixed 5-stage filter. Holds DEPTH ternary entries shared by NUM_TABLES logical tables. Each entry is tagged with a table id. Extracts the key from the PHV at a per-table offset and returns priority (lowest-index) hit, address and action. Valid/ready backpressure on both sides, plus an atomic per-table bulk-clear sequencer. Instances chain to form the rmt_pipeline.

Parameters:
PHV_WIDTH, 512, packet header vector width
KEY_WIDTH, 64, match key width
DEPTH, 16, total entries (power of 2, >=2)
NUM_TABLES, 4, logical tables sharing the entries
ACTION_WIDTH, 64, action word width

Ports:
clk  in  1  clock
rst_n  in  1  async reset, active low
cfg_key_offset  in  NUM_TABLES*OFFW  per-table key bit offset into PHV (OFFW=clog2(PHV_WIDTH))
ent_valid  in  1  entry command valid
ent_ready  out  1  entry command accepted
ent_op  in  2  0=WRITE, 1=INVALIDATE, 2=CLEAR_TABLE, 3=reserved (no-op)
ent_addr  in  AW  entry index (AW=clog2(DEPTH))
ent_table  in  TW  table id (TW=clog2(NUM_TABLES))
ent_data / ent_mask  in  KEY_WIDTH  entry key / care mask (1=compare)
ent_action  in  ACTION_WIDTH  action word
in_valid / in_ready  in / out  1  packet handshake
in_phv  in  PHV_WIDTH  packet PHV
in_table  in  TW  table to search
out_valid / out_ready  out / in  1  result handshake
out_phv  out  PHV_WIDTH  PHV passed through
out_table  out  TW  table searched
out_hit  out  1  match found
out_addr  out  AW  matching index (0 on miss)
out_action  out  ACTION_WIDTH  action of match (0 on miss)
stat_clr  in  1  synchronous clear of statistics
stat_lookups / stat_hits  out  32  saturating counters
hc_rd_addr  in  AW  hit-count read index
hc_rd_data  out  16  hit count, registered 1 cycle

Behaviour:
- Reset: all entries invalid; every output 0 except ent_ready=1 and in_ready=1; FSM in IDLE.
- Key = in_phv[cfg_key_offset[in_table] +: KEY_WIDTH]. Bits past PHV_WIDTH read as 0.
- Match(i) = valid[i] && tbl[i]==in_table && ((key^data[i])&mask[i])==0. Lowest i wins.
- Pipeline, 2 cycles. S1 registers the match vector, PHV and table on the in handshake. S2 registers priority-encoded hit/addr/action. Result is visible at out_* 2 cycles after acceptance when out_ready stays high.
- Backpressure: a stage advances when its successor is empty or being drained. in_ready = !busy && (S1 empty || S1 advancing). S2 holds all outputs stable while out_valid && !out_ready. No bubbles at full throughput.
- Lookups compare against entry contents at the acceptance cycle. A WRITE or INVALIDATE handshaken in the same cycle is seen only by later lookups. An in-flight hit returns the action latched at S1, so S1 also registers action rows.
- WRITE / INVALIDATE: single cycle, ent_ready=1 in IDLE.
- CLEAR_TABLE FSM: IDLE -> CLEAR on handshake; a sweep index steps 0..DEPTH-1, one per cycle, invalidating entries whose tbl==ent_table (latched); CLEAR -> IDLE after index DEPTH-1 (DEPTH cycles).
  - ent_ready=0 and in_ready=0 during CLEAR (busy=1). Packets already in S1/S2 drain normally.
- Statistics: stat_lookups increments on each S2 load; stat_hits increments on each S2 load with a hit. Both saturate at 0xFFFFFFFF. stat_clr has priority over an increment in the same cycle.
- Reset mid-sweep or mid-stall: immediate return to reset state; in-flight packets are discarded.

Optional Feature:
RMT_HIT_COUNT_EN
- Defined: per-entry 16-bit saturating hit counter, incremented on S2 load for the winning address. The counter clears when its entry is written, invalidated or swept. hc_rd_data = count[hc_rd_addr], registered.
- Undefined: no counters are built; hc_rd_data is tied to 0.

Decomposition:
- rmt_pkg: ent_op encodings (OP_WRITE, OP_INVALIDATE, OP_CLEAR_TABLE), FSM state enum (ST_IDLE, ST_CLEAR), clog2-based width localparam helpers.
- One sub-module, rmt_prio_enc: DEPTH-bit one-hot-priority encoder giving hit and AW-bit index, used by S2.

Test Plan:
1. Write entry 3 {table 1, data 0x0000_0000_0A00_0001, mask 0x0000_0000_FFFF_FFFF, action 0x55}; offset[1]=112; packet SIP 10.0.0.1 with in_table=1 -> 2 cycles later out_hit=1, out_addr=3, out_action=0x55. Same packet with in_table=0 -> out_hit=0, out_action=0.
2. Entries 2 and 5 both match, entry 5 wildcard (mask 0) -> out_addr=2. Invalidate 2, resend -> out_addr=5.
3. Stream 8 back-to-back packets with out_ready low for cycles 3-6 -> no drop or duplication; out_* stable while stalled; stat_lookups=8.
4. Fill 4 entries for table 2 and 2 for table 0, then CLEAR_TABLE 2 -> ent_ready/in_ready low for exactly DEPTH=16 cycles. Afterwards table-2 lookups miss and table-0 lookups still hit.
5. Same-cycle WRITE of entry 0 and lookup accept -> that lookup misses, the next identical lookup hits.
6. With RMT_HIT_COUNT_EN defined: 3 hits on entry 4 -> hc_rd_data=3 one cycle after hc_rd_addr=4. Rewrite entry 4 -> 0. stat_clr together with a hit -> stat_hits=0.

Source files
------------

// File: rtl/rmt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rmt_pkg
// Description : Shared encodings and width helpers for the RMT match stage.
// Revision    : 1.0
// ============================================================================
package rmt_pkg;

  localparam logic [1:0] OP_WRITE       = 2'd0;
  localparam logic [1:0] OP_INVALIDATE  = 2'd1;
  localparam logic [1:0] OP_CLEAR_TABLE = 2'd2;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } rmt_state_e;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int unsigned rmt_clog2w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rmt_prio_enc.sv
`default_nettype none
// ============================================================================
// Module      : rmt_prio_enc
// Description : Lowest-index-wins priority encoder over a match vector.
// Revision    : 1.0
// ============================================================================
module rmt_prio_enc
  import rmt_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = rmt_clog2w(DEPTH)
) (
  input  logic [DEPTH-1:0] i_vec,
  output logic             o_hit,
  output logic [AW-1:0]    o_idx
);

  always_comb begin
    o_hit = |i_vec;
    o_idx = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = AW'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/rmt_tcam_stage.sv
`default_nettype none
// ============================================================================
// Module      : rmt_tcam_stage
// Description : Two-stage ternary match-action stage with per-table bulk clear.
//               Define RMT_HIT_COUNT_EN to build per-entry hit counters.
// Revision    : 1.0
// ============================================================================
module rmt_tcam_stage
  import rmt_pkg::*;
#(
  parameter  int PHV_WIDTH    = 512,
  parameter  int KEY_WIDTH    = 64,
  parameter  int DEPTH        = 16,
  parameter  int NUM_TABLES   = 4,
  parameter  int ACTION_WIDTH = 64,
  localparam int OFFW         = rmt_clog2w(PHV_WIDTH),
  localparam int AW           = rmt_clog2w(DEPTH),
  localparam int TW           = rmt_clog2w(NUM_TABLES)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_TABLES*OFFW-1:0] cfg_key_offset,
  input  logic                       ent_valid,
  output logic                       ent_ready,
  input  logic [1:0]                 ent_op,
  input  logic [AW-1:0]              ent_addr,
  input  logic [TW-1:0]              ent_table,
  input  logic [KEY_WIDTH-1:0]       ent_data,
  input  logic [KEY_WIDTH-1:0]       ent_mask,
  input  logic [ACTION_WIDTH-1:0]    ent_action,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PHV_WIDTH-1:0]       in_phv,
  input  logic [TW-1:0]              in_table,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PHV_WIDTH-1:0]       out_phv,
  output logic [TW-1:0]              out_table,
  output logic                       out_hit,
  output logic [AW-1:0]              out_addr,
  output logic [ACTION_WIDTH-1:0]    out_action,
  input  logic                       stat_clr,
  output logic [31:0]                stat_lookups,
  output logic [31:0]                stat_hits,
  input  logic [AW-1:0]              hc_rd_addr,
  output logic [15:0]                hc_rd_data
);

  logic [DEPTH-1:0]        r_valid;
  logic [TW-1:0]           r_tbl  [DEPTH];
  logic [KEY_WIDTH-1:0]    r_data [DEPTH];
  logic [KEY_WIDTH-1:0]    r_mask [DEPTH];
  logic [ACTION_WIDTH-1:0] r_act  [DEPTH];

  rmt_state_e              r_state;
  logic [AW-1:0]           r_sweep;
  logic [TW-1:0]           r_clr_tbl;

  logic                    r_s1_valid;
  logic [DEPTH-1:0]        r_s1_match;
  logic [PHV_WIDTH-1:0]    r_s1_phv;
  logic [TW-1:0]           r_s1_table;
  logic [ACTION_WIDTH-1:0] r_s1_act [DEPTH];

  logic                    r_out_valid;
  logic [PHV_WIDTH-1:0]    r_out_phv;
  logic [TW-1:0]           r_out_table;
  logic                    r_out_hit;
  logic [AW-1:0]           r_out_addr;
  logic [ACTION_WIDTH-1:0] r_out_action;
  logic [31:0]             r_lookups;
  logic [31:0]             r_hits;

  logic                    w_busy, w_ent_fire, w_in_fire, w_s2_adv, w_s2_load;
  logic                    w_sweep_hit, w_hit;
  logic [AW-1:0]           w_idx;
  logic [OFFW-1:0]         w_off;
  logic [KEY_WIDTH-1:0]    w_key;
  logic [DEPTH-1:0]        w_match;

  assign w_busy      = (r_state == ST_CLEAR);
  assign ent_ready   = !w_busy;
  assign w_ent_fire  = ent_valid && ent_ready;
  assign w_s2_adv    = !r_out_valid || out_ready;
  assign w_s2_load   = r_s1_valid && w_s2_adv;
  assign in_ready    = !w_busy && (!r_s1_valid || w_s2_adv);
  assign w_in_fire   = in_valid && in_ready;
  assign w_sweep_hit = w_busy && r_valid[r_sweep] && (r_tbl[r_sweep] == r_clr_tbl);

  // Zero-extending the PHV makes key bits beyond its top read as 0.
  always_comb begin
    w_off = '0;
    for (int t = 0; t < NUM_TABLES; t++) begin
      if (in_table == TW'(t)) w_off = cfg_key_offset[t*OFFW +: OFFW];
    end
    w_key = KEY_WIDTH'({{KEY_WIDTH{1'b0}}, in_phv} >> w_off);
    for (int i = 0; i < DEPTH; i++) begin
      w_match[i] = r_valid[i] && (r_tbl[i] == in_table) &&
                   (((w_key ^ r_data[i]) & r_mask[i]) == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_state   <= ST_IDLE;
      r_sweep   <= '0;
      r_clr_tbl <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ent_fire) begin
            case (ent_op)
              OP_WRITE:       r_valid[ent_addr] <= 1'b1;
              OP_INVALIDATE:  r_valid[ent_addr] <= 1'b0;
              OP_CLEAR_TABLE: begin
                r_state   <= ST_CLEAR;
                r_sweep   <= '0;
                r_clr_tbl <= ent_table;
              end
              default: ;
            endcase
          end
        end
        ST_CLEAR: begin
          if (w_sweep_hit) r_valid[r_sweep] <= 1'b0;
          r_sweep <= r_sweep + 1'b1;
          if (r_sweep == AW'(DEPTH - 1)) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Entry payloads are qualified by r_valid, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_ent_fire && (ent_op == OP_WRITE)) begin
      r_tbl[ent_addr]  <= ent_table;
      r_data[ent_addr] <= ent_data;
      r_mask[ent_addr] <= ent_mask;
      r_act[ent_addr]  <= ent_action;
    end
    if (w_in_fire) begin
      for (int i = 0; i < DEPTH; i++) r_s1_act[i] <= r_act[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_match <= '0;
      r_s1_phv   <= '0;
      r_s1_table <= '0;
    end else if (w_in_fire) begin
      r_s1_valid <= 1'b1;
      r_s1_match <= w_match;
      r_s1_phv   <= in_phv;
      r_s1_table <= in_table;
    end else if (w_s2_load) begin
      r_s1_valid <= 1'b0;
    end
  end

  rmt_prio_enc #(.DEPTH(DEPTH)) u_prio_enc (
    .i_vec (r_s1_match),
    .o_hit (w_hit),
    .o_idx (w_idx)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_phv    <= '0;
      r_out_table  <= '0;
      r_out_hit    <= 1'b0;
      r_out_addr   <= '0;
      r_out_action <= '0;
    end else begin
      if (w_s2_adv) r_out_valid <= r_s1_valid;
      if (w_s2_load) begin
        r_out_phv    <= r_s1_phv;
        r_out_table  <= r_s1_table;
        r_out_hit    <= w_hit;
        r_out_addr   <= w_idx;
        r_out_action <= w_hit ? r_s1_act[w_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lookups <= '0;
      r_hits    <= '0;
    end else if (stat_clr) begin
      r_lookups <= '0;
      r_hits    <= '0;
    end else if (w_s2_load) begin
      if (r_lookups != '1) r_lookups <= r_lookups + 32'd1;
      if (w_hit && (r_hits != '1)) r_hits <= r_hits + 32'd1;
    end
  end

`ifdef RMT_HIT_COUNT_EN
  logic [15:0] r_hc [DEPTH];
  logic [15:0] r_hc_rd;

  // Any path that (re)defines or removes an entry restarts its count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_hc[i] <= '0;
      r_hc_rd <= '0;
    end else begin
      r_hc_rd <= r_hc[hc_rd_addr];
      for (int i = 0; i < DEPTH; i++) begin
        if ((w_ent_fire && ((ent_op == OP_WRITE) || (ent_op == OP_INVALIDATE)) &&
             (ent_addr == AW'(i))) || (w_sweep_hit && (r_sweep == AW'(i)))) begin
          r_hc[i] <= '0;
        end else if (w_s2_load && w_hit && (w_idx == AW'(i)) && (r_hc[i] != '1)) begin
          r_hc[i] <= r_hc[i] + 16'd1;
        end
      end
    end
  end

  assign hc_rd_data = r_hc_rd;
`else
  logic w_unused_hc;
  assign w_unused_hc = ^hc_rd_addr;
  assign hc_rd_data  = '0;
`endif

  assign out_valid    = r_out_valid;
  assign out_phv      = r_out_phv;
  assign out_table    = r_out_table;
  assign out_hit      = r_out_hit;
  assign out_addr     = r_out_addr;
  assign out_action   = r_out_action;
  assign stat_lookups = r_lookups;
  assign stat_hits    = r_hits;

endmodule
`default_nettype wire

// File: tb/tb_rmt_tcam_stage.sv
`timescale 1ns/1ps
`default_nettype none
// Scoreboard bench for rmt_tcam_stage: a reference table model predicts each
// lookup at acceptance; results are popped and compared as the DUT emits them.
module tb_rmt_tcam_stage;

  localparam int PHV_W = 512, KEY_W = 64, DEPTH = 16, NT = 4, ACT_W = 64;
  localparam int OFFW = 9, AW = 4, TW = 2;
`ifdef RMT_HIT_COUNT_EN
  localparam int HC_EXP = 3;
`else
  localparam int HC_EXP = 0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NT*OFFW-1:0] cfg_key_offset;
  logic ent_valid, ent_ready, in_valid, in_ready, out_valid, out_ready, out_hit, stat_clr;
  logic [1:0] ent_op;
  logic [AW-1:0] ent_addr, out_addr, hc_rd_addr;
  logic [TW-1:0] ent_table, in_table, out_table;
  logic [KEY_W-1:0] ent_data, ent_mask;
  logic [ACT_W-1:0] ent_action, out_action;
  logic [PHV_W-1:0] in_phv, out_phv;
  logic [31:0] stat_lookups, stat_hits;
  logic [15:0] hc_rd_data;

  rmt_tcam_stage dut (
    .clk(clk), .rst_n(rst_n), .cfg_key_offset(cfg_key_offset),
    .ent_valid(ent_valid), .ent_ready(ent_ready), .ent_op(ent_op), .ent_addr(ent_addr),
    .ent_table(ent_table), .ent_data(ent_data), .ent_mask(ent_mask), .ent_action(ent_action),
    .in_valid(in_valid), .in_ready(in_ready), .in_phv(in_phv), .in_table(in_table),
    .out_valid(out_valid), .out_ready(out_ready), .out_phv(out_phv), .out_table(out_table),
    .out_hit(out_hit), .out_addr(out_addr), .out_action(out_action),
    .stat_clr(stat_clr), .stat_lookups(stat_lookups), .stat_hits(stat_hits),
    .hc_rd_addr(hc_rd_addr), .hc_rd_data(hc_rd_data)
  );

  typedef struct {
    logic [PHV_W-1:0] phv;
    logic [TW-1:0]    tbl;
    logic             hit;
    logic [AW-1:0]    addr;
    logic [ACT_W-1:0] act;
  } exp_t;

  exp_t q[$];
  int checks = 0, errors = 0;
  int m_off[NT] = '{0, 112, 200, 480};
  bit m_valid[DEPTH];
  logic [TW-1:0] m_tbl[DEPTH];
  logic [KEY_W-1:0] m_data[DEPTH], m_mask[DEPTH];
  logic [ACT_W-1:0] m_act[DEPTH];
  int m_hits = 0, n_out = 0;
  bit t_in_fire, t_ent_fire, t_ent_rdy, t_in_rdy;
  bit stall_prev = 0;
  logic [PHV_W-1:0] prev_phv;
  logic [TW-1:0] prev_tbl;
  logic prev_hit;
  logic [AW-1:0] prev_addr;
  logic [ACT_W-1:0] prev_act;
  logic last_hit;
  logic [AW-1:0] last_addr;
  logic [ACT_W-1:0] last_act;

  function automatic exp_t model_lookup(input logic [PHV_W-1:0] phv, input logic [TW-1:0] tbl);
    exp_t e;
    logic [PHV_W+KEY_W-1:0] ext;
    logic [KEY_W-1:0] key;
    ext = {{KEY_W{1'b0}}, phv};
    key = ext[m_off[tbl] +: KEY_W];
    e.phv = phv; e.tbl = tbl; e.hit = 1'b0; e.addr = '0; e.act = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!e.hit && m_valid[i] && m_tbl[i] == tbl && ((key ^ m_data[i]) & m_mask[i]) == '0) begin
        e.hit = 1'b1; e.addr = AW'(i); e.act = m_act[i];
      end
    end
    return e;
  endfunction

  function automatic logic [PHV_W-1:0] make_phv(input int tbl, input logic [KEY_W-1:0] key);
    logic [PHV_W+KEY_W-1:0] ext;
    for (int w = 0; w < (PHV_W + KEY_W) / 32; w++) ext[w*32 +: 32] = $urandom;
    ext[m_off[tbl] +: KEY_W] = key;
    return ext[PHV_W-1:0];
  endfunction

  task automatic model_apply();
    case (ent_op)
      2'd0: begin
        m_valid[ent_addr] = 1'b1; m_tbl[ent_addr] = ent_table;
        m_data[ent_addr] = ent_data; m_mask[ent_addr] = ent_mask; m_act[ent_addr] = ent_action;
      end
      2'd1: m_valid[ent_addr] = 1'b0;
      2'd2: for (int i = 0; i < DEPTH; i++) if (m_tbl[i] == ent_table) m_valid[i] = 1'b0;
      default: ;
    endcase
  endtask

  // One clock: sample at the falling edge, score outputs, record handshakes.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    t_in_fire = in_valid && in_ready;
    t_ent_fire = ent_valid && ent_ready;
    t_ent_rdy = ent_ready;
    t_in_rdy = in_ready;
    if (stall_prev) begin
      checks++;
      if (out_valid !== 1'b1 || out_phv !== prev_phv || out_tbl_hit_changed()) begin
        errors++;
        $display("FAIL stall_hold: valid=%b hit=%b addr=%0d act=%h, held hit=%b addr=%0d act=%h",
                 out_valid, out_hit, out_addr, out_action, prev_hit, prev_addr, prev_act);
      end
    end
    if (out_valid === 1'b1 && out_ready) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: hit=%b addr=%0d with empty scoreboard", out_hit, out_addr);
      end else begin
        e = q.pop_front();
        if (out_hit !== e.hit || out_addr !== e.addr || out_action !== e.act ||
            out_table !== e.tbl || out_phv !== e.phv) begin
          errors++;
          $display("FAIL result: got hit=%b addr=%0d act=%h tbl=%0d phv_lo=%h, want hit=%b addr=%0d act=%h tbl=%0d phv_lo=%h",
                   out_hit, out_addr, out_action, out_table, out_phv[63:0],
                   e.hit, e.addr, e.act, e.tbl, e.phv[63:0]);
        end
        n_out++;
        last_hit = out_hit; last_addr = out_addr; last_act = out_action;
      end
    end
    stall_prev = out_valid && !out_ready;
    prev_phv = out_phv; prev_tbl = out_table; prev_hit = out_hit;
    prev_addr = out_addr; prev_act = out_action;
    if (t_in_fire) begin
      e = model_lookup(in_phv, in_table);
      q.push_back(e);
      if (e.hit) m_hits++;
    end
    if (t_ent_fire) model_apply();
    @(posedge clk); #1;
  endtask

  function automatic bit out_tbl_hit_changed();
    return out_table !== prev_tbl || out_hit !== prev_hit || out_addr !== prev_addr ||
           out_action !== prev_act;
  endfunction

  task automatic ent_cmd(input logic [1:0] op, input int addr, input int tbl,
                         input logic [KEY_W-1:0] data, input logic [KEY_W-1:0] mask,
                         input logic [ACT_W-1:0] act);
    bit done = 0;
    ent_valid = 1'b1; ent_op = op; ent_addr = AW'(addr); ent_table = TW'(tbl);
    ent_data = data; ent_mask = mask; ent_action = act;
    for (int i = 0; i < 40 && !done; i++) begin tick(); done = t_ent_fire; end
    ent_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL ent_cmd_timeout: op=%0d addr=%0d never accepted", op, addr);
    end
  endtask

  task automatic send(input logic [PHV_W-1:0] phv, input int tbl);
    bit done = 0;
    in_valid = 1'b1; in_phv = phv; in_table = TW'(tbl);
    for (int i = 0; i < 40 && !done; i++) begin tick(); done = t_in_fire; end
    in_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL send_timeout: table=%0d never accepted", tbl);
    end
  endtask

  task automatic drain();
    out_ready = 1'b1;
    for (int i = 0; i < 20 && (q.size() != 0 || out_valid); i++) tick();
    if (q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding, want 0", q.size());
    end
  endtask

  task automatic do_reset();
    ent_valid = 0; in_valid = 0; out_ready = 1; stat_clr = 0; hc_rd_addr = '0;
    ent_op = '0; ent_addr = '0; ent_table = '0; ent_data = '0; ent_mask = '0; ent_action = '0;
    in_phv = '0; in_table = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    q.delete(); stall_prev = 0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({out_valid, out_hit, out_addr, out_action, out_table} !== '0 || out_phv !== '0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b hit=%b addr=%0d act=%h, want all 0",
               out_valid, out_hit, out_addr, out_action);
    end
    checks++;
    if (ent_ready !== 1'b1 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_ready: ent_ready=%b in_ready=%b, want 1 1", ent_ready, in_ready);
    end
    checks++;
    if (stat_lookups !== 32'd0 || stat_hits !== 32'd0 || hc_rd_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_stats: lookups=%0d hits=%0d hc=%0d, want 0", stat_lookups, stat_hits, hc_rd_data);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_lookup_basic();
    logic [PHV_W-1:0] p = make_phv(1, 64'h1234_5678_0A00_0001);
    ent_cmd(2'd0, 3, 1, 64'h0000_0000_0A00_0001, 64'h0000_0000_FFFF_FFFF, 64'h55);
    send(p, 1); drain();
    checks++;
    if (last_hit !== 1'b1 || last_addr !== 4'd3 || last_act !== 64'h55) begin
      errors++; $display("FAIL basic_hit: hit=%b addr=%0d act=%h, want 1 3 55", last_hit, last_addr, last_act);
    end
    send(p, 0); drain();
    checks++;
    if (last_hit !== 1'b0 || last_addr !== 4'd0 || last_act !== 64'h0) begin
      errors++; $display("FAIL basic_miss: hit=%b addr=%0d act=%h, want 0 0 0", last_hit, last_addr, last_act);
    end
  endtask

  task automatic test_priority();
    logic [PHV_W-1:0] p = make_phv(0, 64'hFFFF_0000_0A00_0001);
    ent_cmd(2'd0, 2, 0, 64'h0A00_0001, 64'hFFFF_FFFF, 64'h22);
    ent_cmd(2'd0, 5, 0, 64'h0, 64'h0, 64'h5555);
    send(p, 0); drain();
    checks++;
    if (last_addr !== 4'd2 || last_act !== 64'h22) begin
      errors++; $display("FAIL prio_lowest: addr=%0d act=%h, want 2 22", last_addr, last_act);
    end
    ent_cmd(2'd1, 2, 0, '0, '0, '0);
    send(p, 0); drain();
    checks++;
    if (last_hit !== 1'b1 || last_addr !== 4'd5 || last_act !== 64'h5555) begin
      errors++; $display("FAIL prio_after_inval: hit=%b addr=%0d, want 1 5", last_hit, last_addr);
    end
    ent_cmd(2'd1, 5, 0, '0, '0, '0);
  endtask

  // Table 3 keys start 32 bits below the PHV top; the upper key half must read 0.
  task automatic test_boundary();
    logic [PHV_W-1:0] p = make_phv(3, 64'h0000_0000_CAFE_F00D);
    p[31:0] = 32'hFFFF_FFFF;
    ent_cmd(2'd0, 1, 3, 64'hFFFF_FFFF_CAFE_F00D, '1, 64'h11);
    ent_cmd(2'd0, 13, 3, 64'h0000_0000_CAFE_F00D, '1, 64'hD);
    send(p, 3); drain();
    checks++;
    if (last_hit !== 1'b1 || last_addr !== 4'd13) begin
      errors++; $display("FAIL key_past_top: hit=%b addr=%0d, want 1 13", last_hit, last_addr);
    end
  endtask

  task automatic test_back_to_back();
    logic [PHV_W-1:0] pk[8];
    int tb_[8];
    int p = 0, c = 0, start_out;
    for (int i = 0; i < 8; i++) begin
      case (i % 3)
        0: begin tb_[i] = 1; pk[i] = make_phv(1, {32'(i), 32'h0A00_0001}); end
        1: begin tb_[i] = 3; pk[i] = make_phv(3, 64'h0000_0000_CAFE_F00D); end
        default: begin tb_[i] = 0; pk[i] = make_phv(0, 64'(i)); end
      endcase
    end
    stat_clr = 1'b1; tick(); stat_clr = 1'b0;
    m_hits = 0; start_out = n_out;
    for (c = 0; c < 40 && p < 8; c++) begin
      in_valid = 1'b1; in_phv = pk[p]; in_table = TW'(tb_[p]);
      out_ready = !(c >= 3 && c <= 6);
      tick();
      if (t_in_fire) p++;
    end
    in_valid = 1'b0;
    checks++;
    if (p != 8 || c > 12) begin
      errors++; $display("FAIL b2b_accept: accepted %0d in %0d cycles, want 8 in <=12", p, c);
    end
    drain();
    checks++;
    if (n_out - start_out != 8) begin
      errors++; $display("FAIL b2b_count: outputs=%0d, want 8", n_out - start_out);
    end
    checks++;
    if (stat_lookups !== 32'd8 || stat_hits !== 32'(m_hits)) begin
      errors++; $display("FAIL b2b_stats: lookups=%0d hits=%0d, want 8 %0d", stat_lookups, stat_hits, m_hits);
    end
  endtask

  task automatic test_clear_table();
    int n_ent = 0, n_in = 0;
    for (int i = 0; i < 4; i++) ent_cmd(2'd0, 6 + i, 2, 64'hABCD_0000 + 64'(i), '1, 64'h200 + 64'(i));
    ent_cmd(2'd0, 10, 0, 64'h1000, '1, 64'hA0);
    ent_cmd(2'd0, 11, 0, 64'h1001, '1, 64'hA1);
    send(make_phv(2, 64'hABCD_0002), 2); drain();
    ent_cmd(2'd2, 0, 2, '0, '0, '0);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (t_ent_rdy && t_in_rdy) break;
      if (!t_ent_rdy) n_ent++;
      if (!t_in_rdy) n_in++;
    end
    checks++;
    if (n_ent != DEPTH || n_in != DEPTH) begin
      errors++; $display("FAIL clear_busy: ent_ready low %0d in_ready low %0d cycles, want 16", n_ent, n_in);
    end
    send(make_phv(2, 64'hABCD_0001), 2); drain();
    checks++;
    if (last_hit !== 1'b0) begin
      errors++; $display("FAIL clear_t2_miss: hit=%b addr=%0d, want 0", last_hit, last_addr);
    end
    send(make_phv(0, 64'h1000), 0); drain();
    checks++;
    if (last_hit !== 1'b1 || last_addr !== 4'd10 || last_act !== 64'hA0) begin
      errors++; $display("FAIL clear_t0_hit: hit=%b addr=%0d, want 1 10", last_hit, last_addr);
    end
  endtask

  task automatic test_same_cycle();
    logic [PHV_W-1:0] p = make_phv(1, 64'h0000_BEEF_C0A8_0101);
    ent_valid = 1'b1; ent_op = 2'd0; ent_addr = '0; ent_table = 2'd1;
    ent_data = 64'h0000_BEEF_C0A8_0101; ent_mask = '1; ent_action = 64'hBEEF;
    in_valid = 1'b1; in_phv = p; in_table = 2'd1;
    tick();
    ent_valid = 1'b0; in_valid = 1'b0;
    checks++;
    if (!(t_in_fire && t_ent_fire)) begin
      errors++; $display("FAIL same_cycle_fire: in=%b ent=%b, want 1 1", t_in_fire, t_ent_fire);
    end
    drain();
    checks++;
    if (last_hit !== 1'b0) begin
      errors++; $display("FAIL same_cycle_miss: hit=%b, want 0", last_hit);
    end
    send(p, 1); drain();
    checks++;
    if (last_hit !== 1'b1 || last_addr !== 4'd0 || last_act !== 64'hBEEF) begin
      errors++; $display("FAIL same_cycle_next: hit=%b addr=%0d, want 1 0", last_hit, last_addr);
    end
  endtask

  task automatic test_stats_clr();
    in_valid = 1'b1; in_phv = make_phv(1, 64'h0A00_0001); in_table = 2'd1;
    tick();
    in_valid = 1'b0; stat_clr = 1'b1;
    tick();
    stat_clr = 1'b0;
    tick();
    checks++;
    if (stat_hits !== 32'd0 || stat_lookups !== 32'd0) begin
      errors++; $display("FAIL stat_clr_prio: lookups=%0d hits=%0d, want 0 0", stat_lookups, stat_hits);
    end
    drain();
  endtask

  task automatic test_hit_count();
    logic [PHV_W-1:0] p = make_phv(2, 64'h4444_4444_4444_4444);
    ent_cmd(2'd0, 4, 2, 64'h4444_4444_4444_4444, '1, 64'h44);
    for (int i = 0; i < 3; i++) send(p, 2);
    drain();
    hc_rd_addr = 4'd4;
    tick();
    checks++;
    if (hc_rd_data !== 16'(HC_EXP)) begin
      errors++; $display("FAIL hc_count: hc=%0d, want %0d", hc_rd_data, HC_EXP);
    end
    ent_cmd(2'd0, 4, 2, 64'h4444_4444_4444_4444, '1, 64'h45);
    tick();
    checks++;
    if (hc_rd_data !== 16'd0) begin
      errors++; $display("FAIL hc_rewrite: hc=%0d, want 0", hc_rd_data);
    end
  endtask

  task automatic test_reset_midflight();
    logic [PHV_W-1:0] p = make_phv(1, 64'h0A00_0001);
    out_ready = 1'b0;
    send(p, 1); send(p, 1);
    ent_cmd(2'd2, 0, 3, '0, '0, '0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_hit !== 1'b0 || in_ready !== 1'b1 || ent_ready !== 1'b1 ||
        stat_lookups !== 32'd0) begin
      errors++;
      $display("FAIL async_reset: out_valid=%b hit=%b in_ready=%b ent_ready=%b lookups=%0d",
               out_valid, out_hit, in_ready, ent_ready, stat_lookups);
    end
    q.delete(); stall_prev = 0;
    for (int i = 0; i < DEPTH; i++) m_valid[i] = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
    send(p, 1); drain();
    checks++;
    if (last_hit !== 1'b0) begin
      errors++; $display("FAIL reset_entries: hit=%b, want 0", last_hit);
    end
  endtask

  initial begin
    for (int t = 0; t < NT; t++) cfg_key_offset[t*OFFW +: OFFW] = OFFW'(m_off[t]);
    do_reset();
    test_reset();
    test_lookup_basic();
    test_priority();
    test_boundary();
    test_back_to_back();
    test_clear_table();
    test_same_cycle();
    test_stats_clr();
    test_hit_count();
    test_reset_midflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
